// File: rtl/apb_fifo_responder.sv
// apb_fifo_responder: APB word FIFO mailbox (DATA/STATUS/CTRL/THRESH) with one wait state on pops.
// Define APB_FIFO_IRQ_EN to add the threshold interrupt, CTRL.IRQ_EN and the THRESH register.
module apb_fifo_responder #(
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       PADDR,
    input  logic             PSEL,
    input  logic             PENABLE,
    input  logic             PWRITE,
    input  logic [31:0]      PWDATA,
    output logic [31:0]      PRDATA,
    output logic             PREADY,
    output logic             PSLVERR,
    output logic [CNT_W-1:0] fifo_level,
    output logic             irq
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {IDLE, RD_DONE} state_t;

    state_t           state_q, state_d;
    logic [31:0]      mem [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      rdata_q, rd_val;
    logic [4:0]       cnt5, thresh;
    logic             acc, idle, empty, full, is_data, is_status, is_ctrl, is_thresh;
    logic             rd_wait, wr_done, push, pop, clear, err, err_th, irq_en, unused_ok;

    assign acc        = PSEL & PENABLE;
    assign idle       = state_q == IDLE;
    assign empty      = count_q == '0;
    assign full       = count_q == CNT_W'(DEPTH);
    assign cnt5       = 5'(count_q);
    assign is_data    = PADDR[3:2] == 2'd0;
    assign is_status  = PADDR[3:2] == 2'd1;
    assign is_ctrl    = PADDR[3:2] == 2'd2;
    assign is_thresh  = PADDR[3:2] == 2'd3;
    assign rd_wait    = idle & acc & ~PWRITE & is_data & ~empty;
    assign wr_done    = idle & acc & PWRITE;
    assign push       = wr_done & is_data & ~full;
    assign pop        = ~idle;
    assign clear      = wr_done & is_ctrl & PWDATA[0];
    assign err        = acc & ((is_data & (PWRITE ? full : empty)) | (is_status & PWRITE) | err_th);
    assign fifo_level = count_q;
    assign unused_ok  = ^PADDR[1:0];

`ifdef APB_FIFO_IRQ_EN
    logic       irq_en_q, irq_q;
    logic [4:0] thresh_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_q <= 1'b0;
            thresh_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_done & is_ctrl) irq_en_q <= PWDATA[1];
            if (wr_done & is_thresh) thresh_q <= PWDATA[4:0];
            irq_q <= irq_en_q & (cnt5 >= thresh_q) & (thresh_q != '0);
        end
    end

    assign irq_en = irq_en_q;
    assign thresh = thresh_q;
    assign irq    = irq_q;
    assign err_th = 1'b0;
`else
    assign irq_en = 1'b0;
    assign thresh = '0;
    assign irq    = 1'b0;
    assign err_th = is_thresh;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = rd_wait ? RD_DONE : IDLE;
    end

    // PREADY is gated by rst_n so an aborted transfer drops it immediately
    always_comb begin
        PREADY  = rst_n & (~idle | (acc & ~rd_wait));
        rd_val  = ~idle     ? rdata_q :
                  is_status ? {23'd0, cnt5, 2'b00, full, empty} :
                  is_ctrl   ? {30'd0, irq_en, 1'b0} :
                  is_thresh ? {27'd0, thresh} : '0;
        PRDATA  = (PREADY & acc & ~PWRITE) ? rd_val : '0;
        PSLVERR = PREADY & idle & err;
    end

    always_comb begin
        count_d = clear ? '0 : push ? count_q + CNT_W'(1) : pop ? count_q - CNT_W'(1) : count_q;
        wptr_d  = clear ? '0 : push ? wptr_q + PW'(1) : wptr_q;
        rptr_d  = clear ? '0 : pop ? rptr_q + PW'(1) : rptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            rdata_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (rd_wait) rdata_q <= mem[rptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr_q] <= PWDATA;
    end
endmodule

// File: tb/tb_apb_fifo_responder.sv
// tb_apb_fifo_responder: randomized APB traffic against a queue-based mailbox model.
module tb_apb_fifo_responder;
    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef APB_FIFO_IRQ_EN
    localparam bit HAS_IRQ = 1'b1;
`else
    localparam bit HAS_IRQ = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       PADDR = '0;
    logic             PSEL = 1'b0;
    logic             PENABLE = 1'b0;
    logic             PWRITE = 1'b0;
    logic [31:0]      PWDATA = '0;
    logic [31:0]      PRDATA;
    logic             PREADY;
    logic             PSLVERR;
    logic [CNT_W-1:0] fifo_level;
    logic             irq;

    logic [31:0] q[$];
    bit          m_irq_en = 1'b0;
    int          m_thresh = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    apb_fifo_responder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .fifo_level(fifo_level), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic xfer(input logic [3:0] a, input logic w, input logic [31:0] wd);
        logic [31:0] exp_d;
        logic        exp_e, exp_irq;
        int          exp_w, waits, n;
        exp_d   = '0;
        exp_e   = 1'b0;
        exp_w   = 0;
        n       = q.size();
        exp_irq = m_irq_en && n >= m_thresh && m_thresh != 0;
        case (a[3:2])
            2'd0: if (w) begin
                      if (n == DEPTH) exp_e = 1'b1;
                      else q.push_back(wd);
                  end else if (n == 0) exp_e = 1'b1;
                  else begin
                      exp_w = 1;
                      exp_d = q.pop_front();
                  end
            2'd1: if (w) exp_e = 1'b1;
                  else exp_d = 32'(n * 16 + (n == DEPTH ? 2 : 0) + (n == 0 ? 1 : 0));
            2'd2: if (w) begin
                      if (wd[0]) q.delete();
                      m_irq_en = HAS_IRQ && wd[1];
                  end else exp_d = {30'd0, m_irq_en, 1'b0};
            default: if (!HAS_IRQ) exp_e = 1'b1;
                     else if (w) m_thresh = int'(wd[4:0]);
                     else exp_d = 32'(m_thresh);
        endcase
        @(posedge clk);
        #1 PADDR = a; PWRITE = w; PWDATA = wd; PSEL = 1'b1; PENABLE = 1'b0;
        #1 chk("irq", irq, exp_irq);
        chk("setup_ready", PREADY, 0);
        @(posedge clk);
        #1 PENABLE = 1'b1;
        #1 waits = 0;
        while (!PREADY && waits < 4) begin
            chk("wait_slverr", PSLVERR, 0);
            chk("wait_prdata", PRDATA, 0);
            @(posedge clk);
            #2 waits++;
        end
        chk("wait_states", waits, exp_w);
        chk("prdata", PRDATA, exp_d);
        chk("pslverr", PSLVERR, exp_e);
        @(posedge clk);
        #1 PSEL = 1'b0; PENABLE = 1'b0;
        chk("fifo_level", fifo_level, q.size());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 chk("rst_pready", PREADY, 0);
        chk("rst_prdata", PRDATA, 0);
        chk("rst_pslverr", PSLVERR, 0);
        chk("rst_irq", irq, 0);
        chk("rst_level", fifo_level, 0);
        #3 rst_n = 1'b1;

        xfer(4'h4, 1'b0, 0);
        xfer(4'h0, 1'b1, 32'h11);
        xfer(4'h0, 1'b1, 32'h22);
        xfer(4'h0, 1'b1, 32'h33);
        repeat (4) xfer(4'h0, 1'b0, 0);

        for (int i = 1; i <= 9; i++) xfer(4'h0, 1'b1, 32'(i));
        xfer(4'h4, 1'b0, 0);
        repeat (8) xfer(4'h0, 1'b0, 0);
        for (int i = 0; i < 8; i++) begin
            xfer(4'h0, 1'b1, $urandom);
            xfer(4'h0, 1'b0, 0);
        end

        for (int i = 0; i < 5; i++) xfer(4'h0, 1'b1, $urandom);
        xfer(4'h8, 1'b1, 32'h1);
        xfer(4'h4, 1'b0, 0);
        xfer(4'h0, 1'b0, 0);
        xfer(4'h8, 1'b0, 0);

        xfer(4'h0, 1'b1, 32'hA5A5_0001);
        xfer(4'h0, 1'b1, 32'hA5A5_0002);
        @(posedge clk);
        #1 PADDR = 4'h0; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
        @(posedge clk);
        #1 PENABLE = 1'b1;
        #1 chk("abort_wait", PREADY, 0);
        @(posedge clk);
        #2 chk("abort_rd_done", PREADY, 1);
        chk("abort_prdata", PRDATA, q[0]);
        rst_n = 1'b0;
        #1 chk("abort_pready", PREADY, 0);
        PSEL = 1'b0; PENABLE = 1'b0;
        q.delete();
        m_irq_en = 1'b0;
        m_thresh = 0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1 chk("abort_level", fifo_level, 0);
        xfer(4'h4, 1'b0, 0);
        xfer(4'h0, 1'b1, 32'hBEEF_0003);
        xfer(4'h0, 1'b0, 0);

`ifdef APB_FIFO_IRQ_EN
        xfer(4'hC, 1'b1, 32'd3);
        xfer(4'h8, 1'b1, 32'h2);
        xfer(4'hC, 1'b0, 0);
        xfer(4'h0, 1'b1, 32'h1);
        xfer(4'h0, 1'b1, 32'h2);
        xfer(4'h0, 1'b1, 32'h3);
        chk("irq_not_yet", irq, 0);
        @(posedge clk);
        #1 chk("irq_rise", irq, 1);
        xfer(4'h0, 1'b0, 0);
        chk("irq_hold", irq, 1);
        @(posedge clk);
        #1 chk("irq_fall", irq, 0);
        xfer(4'h8, 1'b1, 32'h1);
`else
        xfer(4'hC, 1'b1, 32'd3);
        xfer(4'h8, 1'b1, 32'h2);
        xfer(4'h8, 1'b0, 0);
        xfer(4'h0, 1'b1, 32'h1);
        @(posedge clk);
        #1 chk("irq_off", irq, 0);
`endif

        for (int i = 0; i < 300; i++) begin
            int          sel;
            logic [3:0]  a;
            logic        w;
            logic [31:0] wd;
            sel = $urandom_range(9);
            a   = {(sel < 5) ? 2'd0 : (sel < 7) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3, 2'($urandom_range(3))};
            w   = (a[3:2] == 2'd0) ? ($urandom_range(2) != 0) : 1'($urandom_range(1));
            wd  = $urandom;
            if (a[3:2] == 2'd2 && $urandom_range(7) != 0) wd[0] = 1'b0;
            if (a[3:2] == 2'd0 && !w) a[1:0] = 2'b00;
            xfer(a, w, wd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
